legv8_datapath_hs: RTL and testbench

//  Parametrised LEGv8 datapath with a valid/ready control-word port and a req/ack data-memory port.

---
 rtl/legv8_datapath_hs_if.sv | 28 ++
 rtl/legv8_datapath_hs.sv | 189 ++++++++++++++++++
 tb/tb_legv8_datapath_hs.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/legv8_datapath_hs_if.sv
// Control-word channel (valid/ready) and data-memory channel (req/ack) of the LEGv8 datapath.
// The slave modport is the datapath side; master is the controller/memory side.
interface legv8_datapath_hs_if #(
   parameter int DATA_W = 64,
   parameter int RW     = 5,
   parameter int ADDR_W = 13
);
   logic                cw_valid;
   logic                cw_ready;
   logic [3*RW+14:0]    cw;
   logic [DATA_W-1:0]   k;
   logic                mem_req;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   mem_rdata;
   logic                mem_ack;

   modport slave (
      input  cw_valid, cw, k, mem_rdata, mem_ack,
      output cw_ready, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output cw_valid, cw, k, mem_rdata, mem_ack,
      input  cw_ready, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/legv8_datapath_hs.sv
// LEGv8 datapath: register file, ALU, PC and status register behind an
// IDLE/EXEC/MEM sequencer that handles memory wait states and timeouts.
module legv8_datapath_hs #(
   parameter int          DATA_W      = 64,
   parameter int          REG_COUNT   = 32,
   parameter int          RW          = 5,
   parameter int          ADDR_W      = 13,
   parameter logic [63:0] RESET_PC    = 64'd0,
   parameter int          MEM_TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   legv8_datapath_hs_if.slave  bus,
   output logic [DATA_W-1:0]   pc,
   output logic [4:0]          status,
   output logic                busy,
   output logic                err_timeout,
   input  logic [RW-1:0]       dbg_sel,
   output logic [DATA_W-1:0]   dbg_data
);
   localparam int CW_W  = 3*RW + 15;
   localparam int CNT_W = $clog2(MEM_TIMEOUT + 2);
   localparam logic [RW-1:0] XZR = RW'(REG_COUNT - 1);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM} state_t;

   state_t              state;
   logic [CW_W-1:0]     cw_reg;
   logic [DATA_W-1:0]   k_reg;
   logic [DATA_W-1:0]   regs [REG_COUNT];
   logic [DATA_W-1:0]   pc_reg;
   logic [3:0]          flags_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [DATA_W-1:0]   wdata_reg;
   logic                we_reg;
   logic                err_reg;
   logic [CNT_W-1:0]    wait_cnt;

   logic [RW-1:0] da, sa, sb;
   logic [4:0]    fs;
   logic          bsel, asel, reg_write, mem_rd, mem_wr, status_load;
   logic [1:0]    wb_sel, ps;

   assign da          = cw_reg[CW_W-1 -: RW];
   assign sa          = cw_reg[CW_W-1-RW -: RW];
   assign sb          = cw_reg[15 +: RW];
   assign fs          = cw_reg[14:10];
   assign bsel        = cw_reg[9];
   assign asel        = cw_reg[8];
   assign reg_write   = cw_reg[7];
   assign mem_rd      = cw_reg[6];
   assign mem_wr      = cw_reg[5];
   assign status_load = cw_reg[4];
   assign wb_sel      = cw_reg[3:2];
   assign ps          = cw_reg[1:0];

   logic [DATA_W-1:0] a_val, b_val, a_in, b_mux, b_in, a_mux, alu_res, wb_data;
   logic [DATA_W-1:0] pc_plus4, pc_branch;
   logic [DATA_W:0]   sum_ext;
   logic              alu_c, alu_v, alu_n, alu_z;
   logic              mem_op, accept, commit, timeout_hit;

   // XZR reads as zero regardless of array contents.
   always_comb begin
      a_val    = (sa == XZR) ? '0 : regs[sa];
      b_val    = (sb == XZR) ? '0 : regs[sb];
      dbg_data = (dbg_sel == XZR) ? '0 : regs[dbg_sel];
   end

   always_comb begin
      a_in    = fs[1] ? ~a_val : a_val;
      b_mux   = bsel ? k_reg : b_val;
      b_in    = fs[0] ? ~b_mux : b_mux;
      sum_ext = {1'b0, a_in} + {1'b0, b_in} + (DATA_W+1)'(fs[0]);
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (fs[4:2])
         3'd0: alu_res = a_in & b_in;
         3'd1: alu_res = a_in | b_in;
         3'd2: begin
            alu_res = sum_ext[DATA_W-1:0];
            alu_c   = sum_ext[DATA_W];
            alu_v   = (a_in[DATA_W-1] == b_in[DATA_W-1]) &&
                      (sum_ext[DATA_W-1] != a_in[DATA_W-1]);
         end
         3'd3: alu_res = a_in ^ b_in;
         3'd4: alu_res = a_in << b_mux[5:0];
         3'd5: alu_res = a_in >> b_mux[5:0];
         3'd6: alu_res = b_mux;
         default: alu_res = '0;
      endcase
      alu_n = alu_res[DATA_W-1];
      alu_z = (alu_res == '0);
   end

   assign pc_plus4  = pc_reg + DATA_W'(4);
   assign pc_branch = pc_reg + (k_reg << 2);
   assign a_mux     = asel ? k_reg : a_val;

   always_comb begin
      case (wb_sel)
         2'b00:   wb_data = alu_res;
         2'b01:   wb_data = bus.mem_rdata;
         2'b10:   wb_data = b_val;
         default: wb_data = pc_plus4;
      endcase
   end

   assign mem_op      = mem_rd | mem_wr;
   assign bus.cw_ready = (state == S_IDLE) || (state == S_EXEC && !mem_op);
   assign accept      = bus.cw_valid && bus.cw_ready;
   // Memory ops commit only on ack; a timeout abandons the instruction entirely.
   assign commit      = (state == S_EXEC && !mem_op) || (state == S_MEM && bus.mem_ack);
   assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else if (commit && reg_write && da != XZR) begin
         regs[da] <= wb_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cw_reg    <= '0;
         k_reg     <= '0;
         pc_reg    <= DATA_W'(RESET_PC);
         flags_reg <= '0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         we_reg    <= 1'b0;
         err_reg   <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         if (accept) begin
            cw_reg <= bus.cw;
            k_reg  <= bus.k;
         end
         if (commit) begin
            if (status_load) flags_reg <= {alu_v, alu_c, alu_n, alu_z};
            case (ps)
               2'b01:   pc_reg <= pc_plus4;
               2'b10:   pc_reg <= a_mux;
               2'b11:   pc_reg <= pc_branch;
               default: pc_reg <= pc_reg;
            endcase
         end
         case (state)
            S_IDLE: if (accept) state <= S_EXEC;
            S_EXEC: begin
               if (mem_op) begin
                  addr_reg  <= alu_res[ADDR_W-1:0];
                  wdata_reg <= b_val;
                  we_reg    <= mem_wr;
                  wait_cnt  <= '0;
                  state     <= S_MEM;
               end else begin
                  state <= accept ? S_EXEC : S_IDLE;
               end
            end
            S_MEM: begin
               if (bus.mem_ack) begin
                  wait_cnt <= '0;
                  state    <= S_IDLE;
               end else if (timeout_hit) begin
                  err_reg  <= 1'b1;
                  wait_cnt <= '0;
                  state    <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.mem_req   = (state == S_MEM);
   assign bus.mem_we    = we_reg;
   assign bus.mem_addr  = addr_reg;
   assign bus.mem_wdata = wdata_reg;
   assign pc            = pc_reg;
   assign status        = {flags_reg, alu_z};
   assign busy          = (state != S_IDLE);
   assign err_timeout   = err_reg;
endmodule

// File: tb/tb_legv8_datapath_hs.sv
// Directed-vector bench for legv8_datapath_hs with a 4-cycle memory timeout.
module tb_legv8_datapath_hs;
   localparam logic [4:0] FS_ADD = 5'b01000;
   localparam logic [4:0] FS_SUB = 5'b01001;
   localparam logic [4:0] FS_OR  = 5'b00100;
   localparam logic [4:0] FS_XOR = 5'b01100;
   localparam logic [4:0] FS_LSL = 5'b10000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] pc;
   logic [4:0]  status;
   logic        busy, err_timeout;
   logic [4:0]  dbg_sel = '0;
   logic [63:0] dbg_data;
   int checks = 0;
   int errors = 0;

   legv8_datapath_hs_if #(.DATA_W(64), .RW(5), .ADDR_W(13)) bus ();

   legv8_datapath_hs #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .bus(bus), .pc(pc), .status(status), .busy(busy),
      .err_timeout(err_timeout), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   function automatic logic [29:0] mk_cw(input logic [4:0] da, sa, sb, fs,
                                         input logic bsel, asel, rw, mrd, mwr, sl,
                                         input logic [1:0] wb, ps);
      return {da, sa, sb, fs, bsel, asel, rw, mrd, mwr, sl, wb, ps};
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [29:0] c, input logic [63:0] kv);
      bus.cw_valid = 1'b1; bus.cw = c; bus.k = kv;
   endtask

   task automatic test_reset();
      bus.cw_valid = 0; bus.cw = '0; bus.k = '0; bus.mem_ack = 0; bus.mem_rdata = '0;
      rst = 1; repeat (2) tick();
      dbg_sel = 5'd1; #1;
      checks++; if (pc !== 64'd0) begin errors++; $display("FAIL reset_pc: got %0h expected 0", pc); end
      checks++; if (bus.cw_ready !== 1'b1) begin errors++; $display("FAIL reset_cw_ready: got %b expected 1", bus.cw_ready); end
      checks++; if (bus.mem_req !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL reset_ctrl: got req=%b busy=%b err=%b expected 0/0/0", bus.mem_req, busy, err_timeout); end
      checks++; if (status[4:1] !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", status[4:1]); end
      checks++; if (dbg_data !== 64'd0) begin errors++; $display("FAIL reset_x1: got %0h expected 0", dbg_data); end
      rst = 0; tick();
   endtask

   task automatic test_load();
      send(mk_cw(5'd1, 5'd31, 5'd0, FS_ADD, 1, 0, 1, 0, 0, 0, 2'b00, 2'b01), 64'd5);
      tick();
      checks++; if (bus.cw_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL load_exec: got ready=%b busy=%b expected 1/1", bus.cw_ready, busy); end
      checks++; if (pc !== 64'd0) begin errors++; $display("FAIL load_pc_pre: got %0h expected 0", pc); end
      send(mk_cw(5'd2, 5'd1, 5'd1, FS_ADD, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01), 64'd0);
   endtask

   task automatic test_back_to_back();
      tick();
      dbg_sel = 5'd1; #1;
      checks++; if (dbg_data !== 64'd5) begin errors++; $display("FAIL load_x1: got %0h expected 5", dbg_data); end
      checks++; if (pc !== 64'd4) begin errors++; $display("FAIL load_pc: got %0h expected 4", pc); end
      checks++; if (busy !== 1'b1 || bus.cw_ready !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble: got busy=%b ready=%b expected 1/1", busy, bus.cw_ready); end
      bus.cw_valid = 0;
      tick();
      dbg_sel = 5'd2; #1;
      checks++; if (dbg_data !== 64'd10) begin errors++; $display("FAIL b2b_x2: got %0h expected a", dbg_data); end
      checks++; if (pc !== 64'd8 || busy !== 1'b0) begin errors++; $display("FAIL b2b_pc: got pc=%0h busy=%b expected 8/0", pc, busy); end
   endtask

   task automatic test_store();
      send(mk_cw(5'd0, 5'd31, 5'd2, FS_ADD, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00), 64'd16);
      tick();
      checks++; if (bus.cw_ready !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL store_exec: got ready=%b req=%b expected 0/0", bus.cw_ready, bus.mem_req); end
      bus.cw_valid = 0;
      for (int c = 1; c <= 3; c++) begin
         tick();
         checks++;
         if (bus.mem_req !== 1'b1 || bus.cw_ready !== 1'b0 || bus.mem_we !== 1'b1 ||
             bus.mem_addr !== 13'd16 || bus.mem_wdata !== 64'd10) begin
            errors++;
            $display("FAIL store_mem_cycle%0d: got req=%b ready=%b we=%b addr=%0h wdata=%0h expected 1/0/1/10/a",
                     c, bus.mem_req, bus.cw_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata);
         end
      end
      bus.mem_ack = 1;
      tick();
      bus.mem_ack = 0;
      checks++; if (bus.mem_req !== 1'b0 || busy !== 1'b0 || bus.cw_ready !== 1'b1 || pc !== 64'd8) begin errors++; $display("FAIL store_done: got req=%b busy=%b ready=%b pc=%0h expected 0/0/1/8", bus.mem_req, busy, bus.cw_ready, pc); end
   endtask

   task automatic test_load_mem();
      send(mk_cw(5'd3, 5'd31, 5'd0, FS_ADD, 1, 0, 1, 1, 0, 0, 2'b01, 2'b01), 64'd32);
      tick();
      bus.cw_valid = 0;
      tick();
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 13'd32) begin errors++; $display("FAIL ldmem_req: got req=%b we=%b addr=%0h expected 1/0/20", bus.mem_req, bus.mem_we, bus.mem_addr); end
      bus.mem_ack = 1; bus.mem_rdata = 64'hABCD;
      tick();
      bus.mem_ack = 0;
      dbg_sel = 5'd3; #1;
      checks++; if (dbg_data !== 64'hABCD) begin errors++; $display("FAIL ldmem_x3: got %0h expected abcd", dbg_data); end
      checks++; if (busy !== 1'b0 || pc !== 64'd12) begin errors++; $display("FAIL ldmem_idle: got busy=%b pc=%0h expected 0/c", busy, pc); end
   endtask

   task automatic test_timeout();
      bus.mem_rdata = 64'h1234;
      send(mk_cw(5'd4, 5'd31, 5'd0, FS_ADD, 1, 0, 1, 1, 0, 0, 2'b01, 2'b01), 64'd40);
      tick();
      bus.cw_valid = 0;
      repeat (4) tick();
      checks++; if (bus.mem_req !== 1'b1 || err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_4th_cycle: got req=%b err=%b expected 1/0", bus.mem_req, err_timeout); end
      tick();
      dbg_sel = 5'd4; #1;
      checks++; if (err_timeout !== 1'b1 || bus.mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_err: got err=%b req=%b busy=%b expected 1/0/0", err_timeout, bus.mem_req, busy); end
      checks++; if (dbg_data !== 64'd0 || pc !== 64'd12) begin errors++; $display("FAIL timeout_nocommit: got x4=%0h pc=%0h expected 0/c", dbg_data, pc); end
   endtask

   task automatic test_flags();
      send(mk_cw(5'd0, 5'd1, 5'd1, FS_SUB, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00), 64'd0);
      tick(); bus.cw_valid = 0; tick();
      checks++; if (status !== 5'b01011) begin errors++; $display("FAIL flags_x1_minus_x1: got %b expected 01011", status); end
      send(mk_cw(5'd0, 5'd1, 5'd2, FS_SUB, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00), 64'd0);
      tick(); bus.cw_valid = 0; tick();
      checks++; if (status !== 5'b00100) begin errors++; $display("FAIL flags_x1_minus_x2: got %b expected 00100", status); end
      checks++; if (err_timeout !== 1'b1 || pc !== 64'd12) begin errors++; $display("FAIL flags_sticky: got err=%b pc=%0h expected 1/c", err_timeout, pc); end
   endtask

   task automatic test_xzr();
      send(mk_cw(5'd31, 5'd31, 5'd0, FS_ADD, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00), 64'd7);
      tick(); bus.cw_valid = 0; tick();
      dbg_sel = 5'd31; #1;
      checks++; if (dbg_data !== 64'd0) begin errors++; $display("FAIL xzr_write_dropped: got %0h expected 0", dbg_data); end
   endtask

   task automatic test_alu_ops();
      send(mk_cw(5'd5, 5'd2, 5'd0, FS_LSL, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00), 64'd2);
      tick();
      send(mk_cw(5'd6, 5'd3, 5'd0, FS_XOR, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00), 64'h00FF);
      tick();
      send(mk_cw(5'd7, 5'd1, 5'd2, FS_OR, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00), 64'd0);
      tick();
      bus.cw_valid = 0;
      tick();
      dbg_sel = 5'd5; #1;
      checks++; if (dbg_data !== 64'd40) begin errors++; $display("FAIL alu_lsl: got %0h expected 28", dbg_data); end
      dbg_sel = 5'd6; #1;
      checks++; if (dbg_data !== 64'hAB32) begin errors++; $display("FAIL alu_xor: got %0h expected ab32", dbg_data); end
      dbg_sel = 5'd7; #1;
      checks++; if (dbg_data !== 64'd15) begin errors++; $display("FAIL alu_or: got %0h expected f", dbg_data); end
   endtask

   task automatic test_branch();
      send(mk_cw(5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11), 64'd3);
      tick(); bus.cw_valid = 0; tick();
      checks++; if (pc !== 64'd24) begin errors++; $display("FAIL branch_rel: got %0h expected 18", pc); end
      send(mk_cw(5'd0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b10), 64'd100);
      tick(); bus.cw_valid = 0; tick();
      checks++; if (pc !== 64'd100) begin errors++; $display("FAIL branch_abs_k: got %0h expected 64", pc); end
      send(mk_cw(5'd0, 5'd2, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10), 64'd100);
      tick(); bus.cw_valid = 0; tick();
      checks++; if (pc !== 64'd10) begin errors++; $display("FAIL branch_reg: got %0h expected a", pc); end
   endtask

   task automatic test_reset_mid_mem();
      send(mk_cw(5'd0, 5'd31, 5'd2, FS_ADD, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00), 64'd8);
      tick(); bus.cw_valid = 0; tick();
      checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rstmem_pre: got req=%b expected 1", bus.mem_req); end
      dbg_sel = 5'd2;
      #2 rst = 1;
      #1;
      checks++; if (bus.mem_req !== 1'b0 || busy !== 1'b0 || bus.cw_ready !== 1'b1 || err_timeout !== 1'b0) begin errors++; $display("FAIL rstmem_ctrl: got req=%b busy=%b ready=%b err=%b expected 0/0/1/0", bus.mem_req, busy, bus.cw_ready, err_timeout); end
      checks++; if (pc !== 64'd0 || status[4:1] !== 4'b0000 || dbg_data !== 64'd0) begin errors++; $display("FAIL rstmem_state: got pc=%0h flags=%b x2=%0h expected 0/0000/0", pc, status[4:1], dbg_data); end
      tick(); rst = 0; tick();
   endtask

   initial begin
      test_reset();
      test_load();
      test_back_to_back();
      test_store();
      test_load_mem();
      test_timeout();
      test_flags();
      test_xzr();
      test_alu_ops();
      test_branch();
      test_reset_mid_mem();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000ns");
      $fatal(1);
   end
endmodule
